// File: rtl/jtag_sync_arbiter.sv
// jtag_sync_arbiter: round-robin sharing of one synchronizer pulse channel with guard gaps
module jtag_sync_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GUARD_CYCLES = 6,
  localparam int TAG_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic                 clr_ovf_i,
  output logic                 sync_pulse_o,
  output logic [TAG_WIDTH-1:0] sync_tag_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   pending_o,
  output logic [NUM_REQ-1:0]   overflow_o,
  output logic                 busy_o
);
  localparam int CW = $clog2(GUARD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [TAG_WIDTH-1:0] ptr_q, tag_q, win_d;
  logic [NUM_REQ-1:0]   pending_q, overflow_q, grant_q, grant_d;
  logic                 pulse_q, hit_d, issue_d;
  // first pending requester after the last winner, wrapping around
  always_comb begin
    win_d = ptr_q;
    hit_d = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!hit_d && pending_q[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_d = TAG_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
        hit_d = 1'b1;
      end
    issue_d = hit_d && enable_i && (state_q == IDLE || (state_q == GUARD && cnt_q == '0));
    grant_d = issue_d ? NUM_REQ'(1) << win_d : '0;
  end
  // FSM, request latching and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= TAG_WIDTH'(NUM_REQ - 1);
      tag_q      <= '0;
      pulse_q    <= 1'b0;
      grant_q    <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= (pending_q & ~grant_d) | req_i;
      overflow_q <= (overflow_q | (req_i & pending_q & ~grant_d)) & ~{NUM_REQ{clr_ovf_i}};
      pulse_q    <= issue_d;
      grant_q    <= grant_d;
      if (issue_d) begin
        state_q <= ISSUE;
        tag_q   <= win_d;
        ptr_q   <= win_d;
      end else if (state_q == ISSUE) begin
        state_q <= GUARD;
        cnt_q   <= CW'(GUARD_CYCLES - 1);
      end else if (state_q == GUARD) begin
        if (cnt_q == '0) state_q <= IDLE;
        else cnt_q <= cnt_q - 1'b1;
      end
    end
  end
  assign sync_pulse_o = pulse_q;
  assign sync_tag_o   = tag_q;
  assign grant_o      = grant_q;
  assign pending_o    = pending_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_jtag_sync_arbiter.sv
// tb_jtag_sync_arbiter: directed and random stimulus against a time-based reference model
module tb_jtag_sync_arbiter;
  localparam int N = 4;
  localparam int G = 6;
  localparam int TW = $clog2(N);
  logic clk = 1'b0, reset, enable, clr_ovf;
  logic [N-1:0] req;
  logic sync_pulse, busy;
  logic [TW-1:0] sync_tag;
  logic [N-1:0] grant, pending, overflow;
  int errors = 0, checks = 0;
  int m_pend, m_ovf, m_ptr, m_tag, m_grant, m_pulse, now, last;
  bit have;

  jtag_sync_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G)) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable), .req_i(req), .clr_ovf_i(clr_ovf),
    .sync_pulse_o(sync_pulse), .sync_tag_o(sync_tag), .grant_o(grant),
    .pending_o(pending), .overflow_o(overflow), .busy_o(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
    end
  endtask

  // model: a pulse may start only when at least G+1 edges have passed since the previous one
  task automatic model_edge();
    int win, gr;
    bit ok;
    now++;
    if (reset) begin
      m_pend = 0; m_ovf = 0; m_ptr = N - 1; m_tag = 0; m_grant = 0; m_pulse = 0; have = 0;
      return;
    end
    ok = enable && m_pend != 0 && (!have || now - last >= G + 1);
    gr = 0;
    win = -1;
    if (ok)
      for (int k = 1; k <= N; k++)
        if (win < 0 && m_pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (win >= 0) begin
      gr = 1 << win; m_ptr = win; m_tag = win; last = now; have = 1;
    end
    m_ovf = clr_ovf ? 0 : (m_ovf | (int'(req) & m_pend & ~gr));
    m_pend = (m_pend & ~gr) | int'(req);
    m_grant = gr;
    m_pulse = (gr != 0);
  endtask

  task automatic cyc(input bit r, input bit en, input int rq, input bit clr);
    reset = r; enable = en; req = N'(rq); clr_ovf = clr;
    @(posedge clk);
    model_edge();
    #1;
    check("pulse", sync_pulse, m_pulse);
    check("grant", grant, m_grant);
    check("tag", sync_tag, m_tag);
    check("pending", pending, m_pend);
    check("overflow", overflow, m_ovf);
    check("busy", busy, int'(have && now - last <= G));
  endtask

  initial begin
    now = 0; last = 0; have = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 1, 'b0001, 0);
    repeat (10) cyc(0, 1, 0, 0);
    cyc(0, 1, 'b1111, 0);
    repeat (32) cyc(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, (i == 2) ? 'b0101 : 'b0001, 0);
    cyc(0, 1, 0, 1);
    repeat (10) cyc(0, 1, 0, 0);
    cyc(0, 1, 'b0111, 0);
    repeat (9) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (12) cyc(0, 1, 0, 0);
    repeat (5) cyc(0, 0, 'b0100, 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    cyc(0, 1, 'b0010, 0);
    cyc(0, 1, 'b0010, 0);
    repeat (16) cyc(0, 1, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
          $urandom_range(0, 49) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
